seq_detect_ctrl: RTL and testbench

- Controller that sequences one `seq_detect` instance, which has a serial `din`, a registered `flag` and an active-low `rst_n`.
- Accepts parallel words over a valid/ready handshake and clears the detector before each word.
- Shifts each word out LSB-first, one bit per clock, then collects the detector's flag pulses.
- Returns a per-word result: hit count, whether any hit occurred, and the bit index of the first hit.
- Sits between a word-level producer/consumer and the bit-serial detector.

---
 rtl/seq_detect_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word-level front end for a bit-serial "seq_detect" instance.
// Accepts a word, clears the detector, shifts the word out LSB-first, then
// collects the detector's flag pulses into a per-word hit count, a found bit
// and the index of the first bit that produced a flag.
module seq_detect_ctrl #(
    parameter int W        = 8,
    parameter int FLAG_LAT = 1,
    parameter int IDX_W    = $clog2(W),
    parameter int CNT_W    = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             det_din,
    output logic             det_rst_n,
    input  logic             det_flag,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_hits,
    output logic             res_found,
    output logic [IDX_W-1:0] res_first
);

    // Cycle counter spans SHIFT and DRAIN: 0 .. W+FLAG_LAT-1.
    localparam int CYC_W = $clog2(W + FLAG_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       sreg_q, sreg_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic               found_q, found_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic               din_q, din_d;
    logic               rstn_q, rstn_d;
    logic               wrdy_q, wrdy_d;
    logic               rvld_q, rvld_d;
    logic               in_win;

    // State and registered outputs; rst drops everything back to idle/cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cyc_q   <= '0;
            hits_q  <= '0;
            found_q <= 1'b0;
            first_q <= '0;
            din_q   <= 1'b0;
            rstn_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cyc_q   <= cyc_d;
            hits_q  <= hits_d;
            found_q <= found_d;
            first_q <= first_d;
            din_q   <= din_d;
            rstn_q  <= rstn_d;
            wrdy_q  <= wrdy_d;
            rvld_q  <= rvld_d;
        end
    end

    // Next-state logic. Registered outputs are computed for the cycle being
    // entered, so det_din/det_rst_n line up exactly with the state they serve.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cyc_d   = cyc_q;
        hits_d  = hits_q;
        found_d = found_q;
        first_d = first_q;
        din_d   = din_q;
        rstn_d  = rstn_q;
        wrdy_d  = wrdy_q;
        rvld_d  = rvld_q;

        // Flag for bit k shows up FLAG_LAT cycles after SHIFT cycle k.
        in_win = ((state_q == S_SHIFT) || (state_q == S_DRAIN)) &&
                 (cyc_q >= CYC_W'(FLAG_LAT));

        case (state_q)
            S_IDLE: begin
                wrdy_d = 1'b1;
                rstn_d = 1'b1;
                din_d  = 1'b0;
                if (word_valid && wrdy_q) begin
                    sreg_d  = word_in;
                    hits_d  = '0;
                    found_d = 1'b0;
                    first_d = '0;
                    wrdy_d  = 1'b0;
                    rstn_d  = 1'b0;   // one CLR cycle with the detector held in reset
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                rstn_d  = 1'b1;
                din_d   = sreg_q[0];
                sreg_d  = sreg_q >> 1;
                cyc_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(W - 1)) begin
                    din_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    din_d  = sreg_q[0];
                    sreg_d = sreg_q >> 1;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                din_d = 1'b0;
                if (cyc_q == CYC_W'(W + FLAG_LAT - 1)) begin
                    rvld_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rvld_q && res_ready) begin
                    rvld_d  = 1'b0;
                    wrdy_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Hit accounting inside the window; count saturates at W.
        if (in_win && det_flag) begin
            if (hits_q != CNT_W'(W))
                hits_d = hits_q + 1'b1;
            if (!found_q) begin
                found_d = 1'b1;
                first_d = IDX_W'(cyc_q - CYC_W'(FLAG_LAT));
            end
        end
    end

    assign word_ready = wrdy_q;
    assign det_din    = din_q;
    assign det_rst_n  = rstn_q;
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = rvld_q;
    assign res_hits   = hits_q;
    assign res_found  = found_q;
    assign res_first  = first_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a behavioural overlapping-"101"
// detector (registered flag, one cycle latency).
module tb_seq_detect_ctrl;

    localparam int W        = 8;
    localparam int FLAG_LAT = 1;
    localparam int IDX_W    = $clog2(W);
    localparam int CNT_W    = $clog2(W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     word_in;
    logic             word_valid;
    logic             word_ready;
    logic             det_din;
    logic             det_rst_n;
    logic             det_flag;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_hits;
    logic             res_found;
    logic [IDX_W-1:0] res_first;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.W(W), .FLAG_LAT(FLAG_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .det_din   (det_din),
        .det_rst_n (det_rst_n),
        .det_flag  (det_flag),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hits  (res_hits),
        .res_found (res_found),
        .res_first (res_first)
    );

    // Behavioural detector: flag when the last three arrivals are 1,0,1.
    logic [1:0] hist;
    always @(posedge clk) begin
        if (!det_rst_n) begin
            hist     <= 2'b00;
            det_flag <= 1'b0;
        end else begin
            hist     <= {hist[0], det_din};
            det_flag <= ({hist, det_din} == 3'b101);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a word and return just after the accepting edge (CLR cycle).
    task automatic accept(input logic [W-1:0] w, output bit ok);
        int n = 0;
        word_in    = w;
        word_valid = 1'b1;
        while (!word_ready && n < 50) begin
            tick();
            n++;
        end
        ok = word_ready;
        tick();
        word_valid = 1'b0;
    endtask

    // Count edges until res_valid is seen, bounded.
    task automatic wait_res(output bit ok, output int edges);
        edges = 0;
        while (!res_valid && edges < 100) begin
            tick();
            edges++;
        end
        ok = res_valid;
    endtask

    task automatic take_result;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; word_valid = 1'b0; word_in = '0; res_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (word_ready !== 1'b0 || det_rst_n !== 1'b0 || det_din !== 1'b0 || busy !== 1'b0 ||
            res_valid !== 1'b0 || res_hits !== '0 || res_found !== 1'b0 || res_first !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b rst_n=%b din=%b busy=%b vld=%b hits=%0d found=%b first=%0d want all 0",
                     word_ready, det_rst_n, det_din, busy, res_valid, res_hits, res_found, res_first);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (word_ready !== 1'b1 || det_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL first_edge: word_ready=%b det_rst_n=%b want 1 1", word_ready, det_rst_n);
        end
    endtask

    // Scenario 1: serial order and single hit at bit 3.
    task automatic test_serial_order;
        logic [W-1:0] w = 8'b1001_1011;
        bit ok;
        int edges;
        accept(w, ok);
        checks++;
        if (!ok || det_rst_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_cycle: ok=%b det_rst_n=%b busy=%b want 1 0 1", ok, det_rst_n, busy);
        end
        tick();
        for (int k = 0; k < W; k++) begin
            checks++;
            if (det_din !== w[k] || det_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL shift_bit%0d: din=%b rst_n=%b want %b 1", k, det_din, det_rst_n, w[k]);
            end
            tick();
        end
        checks++;
        if (det_din !== 1'b0) begin
            errors++;
            $display("FAIL drain_din: got %b want 0", det_din);
        end
        wait_res(ok, edges);
        checks++;
        if (!ok || res_hits !== 4'd1 || res_found !== 1'b1 || res_first !== 3'd3) begin
            errors++;
            $display("FAIL s1_result: ok=%b hits=%0d found=%b first=%0d want 1 1 1 3",
                     ok, res_hits, res_found, res_first);
        end
        take_result();
    endtask

    // Scenario 2: three hits, first at bit 2, and result latency.
    task automatic test_latency;
        bit ok;
        int edges;
        accept(8'b0101_0101, ok);
        wait_res(ok, edges);
        // The accepting edge is edge 1; res_valid appears after edge 11,
        // i.e. W+FLAG_LAT+1 further edges after the accepting one.
        checks++;
        if (!ok || edges !== W + FLAG_LAT + 1) begin
            errors++;
            $display("FAIL s2_latency: ok=%b edges_after_accept=%0d want %0d", ok, edges, W + FLAG_LAT + 1);
        end
        checks++;
        if (res_hits !== 4'd3 || res_found !== 1'b1 || res_first !== 3'd2) begin
            errors++;
            $display("FAIL s2_result: hits=%0d found=%b first=%0d want 3 1 2", res_hits, res_found, res_first);
        end
        take_result();
    endtask

    // Scenario 3: all-zero and all-one words produce no hits.
    task automatic test_no_hits;
        logic [W-1:0] pats [2] = '{8'h00, 8'hFF};
        bit ok;
        int edges;
        for (int i = 0; i < 2; i++) begin
            accept(pats[i], ok);
            wait_res(ok, edges);
            checks++;
            if (!ok || res_hits !== '0 || res_found !== 1'b0 || res_first !== '0) begin
                errors++;
                $display("FAIL s3_word_%h: ok=%b hits=%0d found=%b first=%0d want 1 0 0 0",
                         pats[i], ok, res_hits, res_found, res_first);
            end
            take_result();
        end
    endtask

    // Scenario 4: result back-pressure blocks new words.
    task automatic test_backpressure;
        bit ok;
        int edges;
        int bad = 0;
        accept(8'b0101_0101, ok);
        wait_res(ok, edges);
        word_in    = 8'b1001_1011;
        word_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!ok || res_valid !== 1'b1 || word_ready !== 1'b0 || res_hits !== 4'd3 ||
                res_found !== 1'b1 || res_first !== 3'd2 || busy !== 1'b1)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL s4_hold: %0d of 20 cycles unstable, want 0", bad);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || word_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s4_release: vld=%b rdy=%b busy=%b want 0 1 0", res_valid, word_ready, busy);
        end
        tick();
        word_valid = 1'b0;
        checks++;
        if (word_ready !== 1'b0 || det_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL s4_accept: rdy=%b rst_n=%b want 0 0", word_ready, det_rst_n);
        end
        wait_res(ok, edges);
        checks++;
        if (!ok || res_hits !== 4'd1 || res_first !== 3'd3) begin
            errors++;
            $display("FAIL s4_next_word: ok=%b hits=%0d first=%0d want 1 1 3", ok, res_hits, res_first);
        end
        take_result();
    endtask

    // Scenario 5: previous word ends ...1,0; new word starts 1,0,1 -> first hit at 2.
    task automatic test_clr_history;
        bit ok;
        int edges;
        accept(8'b0101_0101, ok);
        wait_res(ok, edges);
        take_result();
        accept(8'b0000_0101, ok);
        wait_res(ok, edges);
        checks++;
        if (!ok || res_hits !== 4'd1 || res_found !== 1'b1 || res_first !== 3'd2) begin
            errors++;
            $display("FAIL s5_result: ok=%b hits=%0d found=%b first=%0d want 1 1 1 2",
                     ok, res_hits, res_found, res_first);
        end
        take_result();
    endtask

    // Scenario 6: reset in SHIFT cycle 4, then a clean word.
    task automatic test_mid_reset;
        bit ok;
        int edges;
        int seen = 0;
        accept(8'b0101_0101, ok);
        repeat (5) tick();        // CLR -> SHIFT0 .. SHIFT4
        checks++;
        if (res_hits !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL s6_pre: hits=%0d busy=%b want 1 1", res_hits, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (word_ready !== 1'b0 || det_rst_n !== 1'b0 || det_din !== 1'b0 || busy !== 1'b0 ||
            res_valid !== 1'b0 || res_hits !== '0 || res_found !== 1'b0 || res_first !== '0) begin
            errors++;
            $display("FAIL s6_async: rdy=%b rst_n=%b din=%b busy=%b vld=%b hits=%0d found=%b first=%0d want all 0",
                     word_ready, det_rst_n, det_din, busy, res_valid, res_hits, res_found, res_first);
        end
        for (int c = 0; c < 15; c++) begin
            if (res_valid) seen++;
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (res_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || word_ready !== 1'b1) begin
            errors++;
            $display("FAIL s6_no_result: res_valid cycles=%0d rdy=%b want 0 1", seen, word_ready);
        end
        accept(8'b1001_1011, ok);
        wait_res(ok, edges);
        checks++;
        if (!ok || res_hits !== 4'd1 || res_found !== 1'b1 || res_first !== 3'd3) begin
            errors++;
            $display("FAIL s6_after: ok=%b hits=%0d found=%b first=%0d want 1 1 1 3",
                     ok, res_hits, res_found, res_first);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_serial_order();
        test_latency();
        test_no_hits();
        test_backpressure();
        test_clr_history();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
